wired_bus_resolver: RTL and testbench
=====================================

# wired_bus_resolver

Registered, parametrised multi-driver bus resolver that generalises wired-OR/wired-AND nets to NDRV drivers of WIDTH bits each. It adds a third, exclusive tri-state mode with a bus keeper. Every beat has per-driver enables, conflict detection, a saturating conflict counter and a sticky error flag. It sits between multiple sourcing blocks and a single consumer, replacing implicit `wor`/`wand` net resolution with an explicit, observable, one-cycle pipelined stage.

## Interface
- `WIDTH`, 4: bits per driver and of the resolved bus.
- `NDRV`, 2: number of drivers, ≥1.
- `MODE`, 0: 0 = wired-OR, 1 = wired-AND, 2 = exclusive tri-state with keeper.
- `CNT_W`, 8: conflict counter width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  beat qualifier for driver inputs.
- `drv_en`  in  NDRV  per-driver enable; bit i gates driver i.
- `drv_data`  in  NDRV*WIDTH  driver i occupies bits [i*WIDTH +: WIDTH].
- `clr`  in  1  synchronous clear of counter and sticky flag.
- `out_valid`  out  1  resolved beat present.
- `out_data`  out  WIDTH  resolved bus value, registered.
- `out_parity`  out  1  XOR-reduction of `out_data`, registered with it.
- `conflict`  out  1  the beat now on `out_data` had a conflict.
- `conflict_cnt`  out  CNT_W  saturating count of conflicting valid beats.
- `err_sticky`  out  1  set on any conflict; held until `clr` or `rst`.

## Operation
- Enabled set E = drivers with `drv_en[i]=1`.
- Conflict: |E| ≥ 2 and any two enabled drivers differ in any bit. The definition is identical in all modes. It is evaluated only when `in_valid=1`.
- MODE 0: result = OR over E. Empty E gives all zeros.
- MODE 1: result = AND over E. Empty E gives all ones.
- MODE 2:
  - |E| = 1, or all enabled drivers agree: result = the common value.
  - Empty E: result = keeper value (current `out_data`).
  - Conflict: result = keeper value; `conflict` is still flagged.
- Valid beat: `out_data` and `out_parity` load the result, `out_valid`=1, and `conflict` loads the conflict bit.
- Invalid beat: `out_valid`=0, `conflict`=0, `out_data`/`out_parity` hold. Counter and sticky flag are unaffected.
- Counter: increments by 1 per conflicting valid beat and saturates at 2^CNT_W−1; it never wraps.
- `err_sticky` is set by any conflicting valid beat.
- `clr` and a conflicting valid beat in the same cycle: `conflict_cnt`=1, `err_sticky`=1, because clear is applied first and the new event is counted.
- `clr` alone: `conflict_cnt`=0, `err_sticky`=0.
- Reset values:
  - `out_valid`=0, `conflict`=0, `conflict_cnt`=0, `err_sticky`=0.
  - `out_data`: 0 for MODE 0/2; all ones for MODE 1.
  - `out_parity`: ^`out_data` reset value, i.e. WIDTH[0] for MODE 1, else 0.
- `rst` has priority over `in_valid` and `clr`.

## Timing
- Latency is exactly 1 cycle: inputs sampled at edge t appear on all outputs after edge t.
- No backpressure. One beat per cycle is accepted.
- Back-to-back valid beats each produce one output beat.
- All outputs are registered; there is no combinational input→output path.
- `rst` asserted mid-stream: the next cycle shows reset values regardless of `in_valid`. The in-flight beat is discarded.
- MODE 2 keeper survives any run of invalid or empty beats. Only reset changes it without a valid resolving beat.

## Structure
- Package `wbus_pkg` holds:
  - constants `WBUS_MODE_WOR=0`, `WBUS_MODE_WAND=1`, `WBUS_MODE_TRI=2`;
  - a function returning the per-mode reset/idle value for a given WIDTH.
- Sub-module `wbus_resolve`: purely combinational.
  - Inputs: `drv_en`, `drv_data`, keeper value.
  - Outputs: result and conflict bit.
  - Parametrised on WIDTH/NDRV/MODE.
- The top level holds the output registers, counter and sticky logic.
- MODE is elaboration-time only; an illegal MODE value is an elaboration error.

## Test plan
- MODE 0, NDRV=3, WIDTH=4: valid beat with en=3'b011, d0=4'h3, d1=4'h5 → next cycle out_data=4'h7, out_parity=1, conflict=1, conflict_cnt=1, err_sticky=1.
- MODE 1: valid beat with en=0 → out_data=4'hF, out_parity=0, conflict=0. Then en=3'b110, d1=4'hC, d2=4'hA → out_data=4'h8, conflict=1.
- MODE 2, four consecutive valid beats → outputs in order A, A, 1, 1:
  - d2=4'hA alone → out_data=4'hA;
  - en=0 → holds 4'hA;
  - d0=d1=4'h1 → 4'h1, conflict=0;
  - d0=4'h1, d1=4'h2 → holds 4'h1, conflict=1.
- CNT_W=2: five consecutive conflicting valid beats → conflict_cnt 1,2,3,3,3.
  - Then `clr` alone → 0, err_sticky=0.
  - Then `clr` together with a conflicting beat → conflict_cnt=1, err_sticky=1.
- in_valid=0 with conflicting drivers → out_valid=0, conflict=0, out_data unchanged, conflict_cnt unchanged.
- `rst` pulsed while in_valid=1 (MODE 1) → next cycle out_valid=0, out_data=4'hF, out_parity=0, conflict_cnt=0, err_sticky=0.

Source files
------------

// File: rtl/wbus_pkg.sv
// wbus_pkg: mode constants and per-mode idle value for the wired bus resolver
package wbus_pkg;
  localparam int WBUS_MODE_WOR  = 0;
  localparam int WBUS_MODE_WAND = 1;
  localparam int WBUS_MODE_TRI  = 2;
  localparam int WBUS_MAX_W     = 256;
  // Callers slice the low WIDTH bits; wired-AND idles at all ones, others at zero.
  function automatic logic [WBUS_MAX_W-1:0] wbus_idle(input int mode, input int width);
    return (mode == WBUS_MODE_WAND) ? ({WBUS_MAX_W{1'b1}} >> (WBUS_MAX_W - width)) : '0;
  endfunction
endpackage

// File: rtl/wbus_resolve.sv
// wbus_resolve: combinational resolution of NDRV enabled drivers into one bus value
module wbus_resolve
  import wbus_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NDRV  = 2,
  parameter int MODE  = WBUS_MODE_WOR
) (
  input  logic [NDRV-1:0]       drv_en,
  input  logic [NDRV*WIDTH-1:0] drv_data,
  input  logic [WIDTH-1:0]      keep,
  output logic [WIDTH-1:0]      res,
  output logic                  conflict
);
  logic [WIDTH-1:0] or_v, and_v;
  always_comb begin
    or_v  = '0;
    and_v = '1;
    for (int i = 0; i < NDRV; i++) begin
      if (drv_en[i]) begin
        or_v  = or_v  | drv_data[i*WIDTH +: WIDTH];
        and_v = and_v & drv_data[i*WIDTH +: WIDTH];
      end
    end
  end
  // Enabled drivers all agree exactly when their OR equals their AND.
  assign conflict = (|drv_en) && (or_v != and_v);
  assign res = (MODE == WBUS_MODE_WOR)  ? or_v :
               (MODE == WBUS_MODE_WAND) ? and_v :
               ((|drv_en) && !conflict) ? or_v : keep;
endmodule

// File: rtl/wired_bus_resolver.sv
// wired_bus_resolver: registered multi-driver bus resolver with conflict counter and sticky error
module wired_bus_resolver
  import wbus_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NDRV  = 2,
  parameter int MODE  = WBUS_MODE_WOR,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [NDRV-1:0]       drv_en,
  input  logic [NDRV*WIDTH-1:0] drv_data,
  input  logic                  clr,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_parity,
  output logic                  conflict,
  output logic [CNT_W-1:0]      conflict_cnt,
  output logic                  err_sticky
);
  if (MODE < WBUS_MODE_WOR || MODE > WBUS_MODE_TRI) begin : g_bad_mode
    $error("wired_bus_resolver: illegal MODE %0d", MODE);
  end
  if (NDRV < 1 || WIDTH < 1 || WIDTH > WBUS_MAX_W) begin : g_bad_size
    $error("wired_bus_resolver: illegal NDRV %0d / WIDTH %0d", NDRV, WIDTH);
  end
  localparam logic [WBUS_MAX_W-1:0] IDLE_FULL = wbus_idle(MODE, WIDTH);
  localparam logic [WIDTH-1:0]      IDLE      = IDLE_FULL[WIDTH-1:0];
  logic             valid_q, conf_q, par_q, sticky_q, sticky_d, res_conf, hit;
  logic [WIDTH-1:0] data_q, res;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  wbus_resolve #(.WIDTH(WIDTH), .NDRV(NDRV), .MODE(MODE)) u_resolve (
    .drv_en   (drv_en),
    .drv_data (drv_data),
    .keep     (data_q),
    .res      (res),
    .conflict (res_conf)
  );
  // Clear lands first so a simultaneous conflicting beat is still counted.
  always_comb begin
    hit      = in_valid && res_conf;
    cnt_base = clr ? '0 : cnt_q;
    cnt_d    = (hit && cnt_base != '1) ? cnt_base + CNT_W'(1) : cnt_base;
    sticky_d = (sticky_q && !clr) || hit;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      conf_q   <= 1'b0;
      data_q   <= IDLE;
      par_q    <= ^IDLE;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      valid_q  <= in_valid;
      conf_q   <= hit;
      data_q   <= in_valid ? res : data_q;
      par_q    <= in_valid ? ^res : par_q;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end
  assign out_valid    = valid_q;
  assign out_data     = data_q;
  assign out_parity   = par_q;
  assign conflict     = conf_q;
  assign conflict_cnt = cnt_q;
  assign err_sticky   = sticky_q;
endmodule

// File: tb/tb_wired_bus_resolver.sv
// tb_wired_bus_resolver: directed checks of OR, AND and tri-state resolvers sharing one stimulus
module tb_wired_bus_resolver;
  logic        clk = 1'b0;
  logic        rst, in_valid, clr;
  logic [2:0]  drv_en;
  logic [11:0] drv_data;
  logic        v0, p0, c0, s0, v1, p1, c1, s1, v2, p2, c2, s2;
  logic [3:0]  d0, d1, d2;
  logic [1:0]  n0;
  logic [7:0]  n1, n2;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  wired_bus_resolver #(.WIDTH(4), .NDRV(3), .MODE(0), .CNT_W(2)) u_or (
    .clk(clk), .rst(rst), .in_valid(in_valid), .drv_en(drv_en), .drv_data(drv_data), .clr(clr),
    .out_valid(v0), .out_data(d0), .out_parity(p0), .conflict(c0), .conflict_cnt(n0), .err_sticky(s0));
  wired_bus_resolver #(.WIDTH(4), .NDRV(3), .MODE(1), .CNT_W(8)) u_and (
    .clk(clk), .rst(rst), .in_valid(in_valid), .drv_en(drv_en), .drv_data(drv_data), .clr(clr),
    .out_valid(v1), .out_data(d1), .out_parity(p1), .conflict(c1), .conflict_cnt(n1), .err_sticky(s1));
  wired_bus_resolver #(.WIDTH(4), .NDRV(3), .MODE(2), .CNT_W(8)) u_tri (
    .clk(clk), .rst(rst), .in_valid(in_valid), .drv_en(drv_en), .drv_data(drv_data), .clr(clr),
    .out_valid(v2), .out_data(d2), .out_parity(p2), .conflict(c2), .conflict_cnt(n2), .err_sticky(s2));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic v, input logic [2:0] en, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    in_valid = v;
    drv_en   = en;
    drv_data = {c, b, a};
    step();
  endtask
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; clr = 1'b0; drv_en = '0; drv_data = '0;
    step();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL reset_or_valid: got %b want 0", v0); end
    checks++; if (d0 !== 4'h0) begin errors++; $display("FAIL reset_or_data: got %h want 0", d0); end
    checks++; if (p0 !== 1'b0) begin errors++; $display("FAIL reset_or_parity: got %b want 0", p0); end
    checks++; if (n0 !== 2'd0 || s0 !== 1'b0) begin errors++; $display("FAIL reset_or_cnt: got %0d/%b want 0/0", n0, s0); end
    checks++; if (d1 !== 4'hF || p1 !== 1'b0) begin errors++; $display("FAIL reset_and_data: got %h/%b want F/0", d1, p1); end
    checks++; if (d2 !== 4'h0 || c2 !== 1'b0) begin errors++; $display("FAIL reset_tri_data: got %h/%b want 0/0", d2, c2); end
  endtask
  task automatic test_wor();
    do_reset();
    beat(1'b1, 3'b011, 4'h3, 4'h5, 4'h0);
    checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL wor_valid: got %b want 1", v0); end
    checks++; if (d0 !== 4'h7) begin errors++; $display("FAIL wor_data: got %h want 7", d0); end
    checks++; if (p0 !== 1'b1) begin errors++; $display("FAIL wor_parity: got %b want 1", p0); end
    checks++; if (c0 !== 1'b1) begin errors++; $display("FAIL wor_conflict: got %b want 1", c0); end
    checks++; if (n0 !== 2'd1 || s0 !== 1'b1) begin errors++; $display("FAIL wor_cnt: got %0d/%b want 1/1", n0, s0); end
  endtask
  task automatic test_wand();
    do_reset();
    beat(1'b1, 3'b000, 4'h3, 4'hC, 4'hA);
    checks++; if (d1 !== 4'hF || p1 !== 1'b0) begin errors++; $display("FAIL wand_empty: got %h/%b want F/0", d1, p1); end
    checks++; if (c1 !== 1'b0) begin errors++; $display("FAIL wand_empty_conflict: got %b want 0", c1); end
    beat(1'b1, 3'b110, 4'h3, 4'hC, 4'hA);
    checks++; if (d1 !== 4'h8 || p1 !== 1'b1) begin errors++; $display("FAIL wand_data: got %h/%b want 8/1", d1, p1); end
    checks++; if (c1 !== 1'b1 || n1 !== 8'd1) begin errors++; $display("FAIL wand_conflict: got %b/%0d want 1/1", c1, n1); end
  endtask
  task automatic test_tri();
    do_reset();
    beat(1'b1, 3'b100, 4'h0, 4'h0, 4'hA);
    checks++; if (d2 !== 4'hA || c2 !== 1'b0) begin errors++; $display("FAIL tri_single: got %h/%b want A/0", d2, c2); end
    beat(1'b1, 3'b000, 4'h0, 4'h0, 4'hA);
    checks++; if (d2 !== 4'hA || v2 !== 1'b1) begin errors++; $display("FAIL tri_keep_empty: got %h/%b want A/1", d2, v2); end
    beat(1'b1, 3'b011, 4'h1, 4'h1, 4'hA);
    checks++; if (d2 !== 4'h1 || c2 !== 1'b0) begin errors++; $display("FAIL tri_agree: got %h/%b want 1/0", d2, c2); end
    beat(1'b1, 3'b011, 4'h1, 4'h2, 4'hA);
    checks++; if (d2 !== 4'h1 || c2 !== 1'b1) begin errors++; $display("FAIL tri_conflict_keep: got %h/%b want 1/1", d2, c2); end
    checks++; if (p2 !== 1'b1 || n2 !== 8'd1) begin errors++; $display("FAIL tri_parity_cnt: got %b/%0d want 1/1", p2, n2); end
    beat(1'b0, 3'b100, 4'h0, 4'h0, 4'hE);
    beat(1'b0, 3'b000, 4'h0, 4'h0, 4'hE);
    checks++; if (d2 !== 4'h1 || v2 !== 1'b0) begin errors++; $display("FAIL tri_keep_idle: got %h/%b want 1/0", d2, v2); end
  endtask
  task automatic test_saturate();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      beat(1'b1, 3'b011, 4'h3, 4'h5, 4'h0);
      checks++; if (n0 !== exp_cnt[k]) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", k, n0, exp_cnt[k]); end
    end
    clr = 1'b1;
    beat(1'b0, 3'b011, 4'h3, 4'h5, 4'h0);
    checks++; if (n0 !== 2'd0 || s0 !== 1'b0) begin errors++; $display("FAIL clr_alone: got %0d/%b want 0/0", n0, s0); end
    beat(1'b1, 3'b011, 4'h3, 4'h5, 4'h0);
    checks++; if (n0 !== 2'd1 || s0 !== 1'b1) begin errors++; $display("FAIL clr_with_hit: got %0d/%b want 1/1", n0, s0); end
    clr = 1'b0;
  endtask
  task automatic test_invalid();
    beat(1'b0, 3'b011, 4'h9, 4'h6, 4'h0);
    checks++; if (v0 !== 1'b0 || c0 !== 1'b0) begin errors++; $display("FAIL inv_flags: got %b/%b want 0/0", v0, c0); end
    checks++; if (d0 !== 4'h7 || p0 !== 1'b1) begin errors++; $display("FAIL inv_hold: got %h/%b want 7/1", d0, p0); end
    checks++; if (n0 !== 2'd1 || s0 !== 1'b1) begin errors++; $display("FAIL inv_cnt: got %0d/%b want 1/1", n0, s0); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    beat(1'b1, 3'b001, 4'h9, 4'h0, 4'h0);
    checks++; if (d0 !== 4'h9 || p0 !== 1'b0 || c0 !== 1'b0) begin errors++; $display("FAIL b2b_0: got %h/%b/%b want 9/0/0", d0, p0, c0); end
    beat(1'b1, 3'b111, 4'h6, 4'h6, 4'h6);
    checks++; if (d0 !== 4'h6 || c0 !== 1'b0 || v0 !== 1'b1) begin errors++; $display("FAIL b2b_1: got %h/%b/%b want 6/0/1", d0, c0, v0); end
    beat(1'b1, 3'b110, 4'h6, 4'h8, 4'h1);
    checks++; if (d0 !== 4'h9 || c0 !== 1'b1 || n0 !== 2'd1) begin errors++; $display("FAIL b2b_2: got %h/%b/%0d want 9/1/1", d0, c0, n0); end
  endtask
  task automatic test_rst_mid();
    do_reset();
    beat(1'b1, 3'b110, 4'h0, 4'hC, 4'hA);
    checks++; if (n1 !== 8'd1 || d1 !== 4'h8) begin errors++; $display("FAIL pre_rst: got %0d/%h want 1/8", n1, d1); end
    rst = 1'b1;
    beat(1'b1, 3'b110, 4'h0, 4'hC, 4'hA);
    rst = 1'b0;
    checks++; if (v1 !== 1'b0 || d1 !== 4'hF || p1 !== 1'b0) begin errors++; $display("FAIL rst_mid_data: got %b/%h/%b want 0/F/0", v1, d1, p1); end
    checks++; if (n1 !== 8'd0 || s1 !== 1'b0) begin errors++; $display("FAIL rst_mid_cnt: got %0d/%b want 0/0", n1, s1); end
  endtask
  initial begin
    test_reset();
    test_wor();
    test_wand();
    test_tri();
    test_saturate();
    test_invalid();
    test_back_to_back();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
